fifo_write_packer: RTL and testbench

Write-domain front end for the async FIFO. It accepts a narrow valid/ready stream in the `write_clk` domain and packs `RATIO` consecutive beats into one wide FIFO word. It tags each word with a beat count and an end-of-packet flag, then drives the FIFO write port while honouring `p_write_full`. The read-domain unpacker uses the tag fields to restore the original narrow stream.

---
 rtl/async_fifo_pkg.sv | 30 +++
 rtl/fifo_write_packer_if.sv | 26 ++
 rtl/fifo_write_packer.sv | 98 +++++++++
 tb/tb_fifo_write_packer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared word-layout helpers for the async FIFO write packer and read unpacker.
// Both sides call the same functions so field positions can never drift apart.
package async_fifo_pkg;

  // Width of the beat-count field (never narrower than one bit).
  function automatic int cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Total FIFO word width: data lanes + count field + last flag.
  function automatic int word_bits(input int in_bits, input int ratio);
    return ratio * in_bits + cnt_w(ratio) + 1;
  endfunction

  // LSB of data lane i.
  function automatic int lane_base(input int in_bits, input int i);
    return i * in_bits;
  endfunction

  // LSB of the count field.
  function automatic int cnt_off(input int in_bits, input int ratio);
    return ratio * in_bits;
  endfunction

  // Position of the end-of-packet flag (word MSB).
  function automatic int last_bit(input int in_bits, input int ratio);
    return ratio * in_bits + cnt_w(ratio);
  endfunction

endpackage

// File: rtl/fifo_write_packer_if.sv
// Narrow input stream plus FIFO write port of the write-side packer.
// master: upstream source / FIFO model; slave: the packer.
interface fifo_write_packer_if #(
  parameter int IN_BITS = 8,
  parameter int RATIO   = 4
);
  localparam int WORD_BITS = async_fifo_pkg::word_bits(IN_BITS, RATIO);

  logic                 s_valid;
  logic                 s_ready;
  logic [IN_BITS-1:0]   s_data;
  logic                 s_last;
  logic                 p_write_en;
  logic [WORD_BITS-1:0] p_write_data;
  logic                 p_write_full;

  modport master (
    output s_valid, s_data, s_last, p_write_full,
    input  s_ready, p_write_en, p_write_data
  );

  modport slave (
    input  s_valid, s_data, s_last, p_write_full,
    output s_ready, p_write_en, p_write_data
  );
endinterface

// File: rtl/fifo_write_packer.sv
// Write-domain packer: gathers RATIO narrow beats into one tagged FIFO word
// and drives the FIFO write port behind a single holding register.
// Optional partial-word flush on idle: define FIFO_WRITE_PACKER_TIMEOUT_EN.
module fifo_write_packer #(
  parameter int IN_BITS = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              write_clk,
  input  logic              write_rst_n,
  fifo_write_packer_if.slave bus
);
  import async_fifo_pkg::*;

  localparam int CNT_W     = cnt_w(RATIO);
  localparam int DATA_BITS = RATIO * IN_BITS;
  localparam int WORD_BITS = word_bits(IN_BITS, RATIO);

  if (RATIO < 1 || (RATIO & (RATIO - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fifo_write_packer: RATIO must be a power of two and TIMEOUT >= 1");
  end

  logic [DATA_BITS-1:0] acc, acc_merged, load_data;
  logic [CNT_W-1:0]     lane, load_cnt;
  logic                 load_last;
  logic [WORD_BITS-1:0] out_word, next_word;
  logic                 out_valid;
  logic                 accept, complete, flush, load;

  // Holding register free or draining this cycle -> can take a beat.
  assign bus.s_ready      = !out_valid || !bus.p_write_full;
  assign bus.p_write_en   = out_valid && !bus.p_write_full;
  assign bus.p_write_data = out_word;

  assign accept   = bus.s_valid && bus.s_ready;
  assign complete = accept && ((lane == CNT_W'(RATIO - 1)) || bus.s_last);
  assign load     = complete || flush;

`ifdef FIFO_WRITE_PACKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              idle;

  assign idle  = (lane != '0) && !accept;
  // A blocked flush keeps asserting until the holding register frees.
  assign flush = idle && (idle_cnt >= IDLE_W'(TIMEOUT - 1)) && bus.s_ready;

  // Idle counter: counts while a partial word sits untouched, saturates at TIMEOUT.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n)                  idle_cnt <= '0;
    else if (!idle || flush)           idle_cnt <= '0;
    else if (idle_cnt != IDLE_W'(TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign flush = 1'b0;
`endif

  // Merge the incoming beat into its lane and assemble the tagged word.
  always_comb begin
    acc_merged = acc;
    acc_merged[lane_base(IN_BITS, int'(lane)) +: IN_BITS] = bus.s_data;
    load_data = flush ? acc : acc_merged;
    load_cnt  = flush ? lane - 1'b1 : lane;
    load_last = flush ? 1'b0 : bus.s_last;
    next_word = '0;
    next_word[DATA_BITS-1:0] = load_data;
    next_word[cnt_off(IN_BITS, RATIO) +: CNT_W] = load_cnt;
    next_word[last_bit(IN_BITS, RATIO)] = load_last;
  end

  // Accumulator and lane pointer; cleared whenever a word leaves.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      acc  <= '0;
      lane <= '0;
    end else if (complete || flush) begin
      acc  <= '0;
      lane <= '0;
    end else if (accept) begin
      acc  <= acc_merged;
      lane <= lane + 1'b1;
    end
  end

  // Holding register: reload on completion/flush, release on FIFO write.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_word  <= next_word;
      out_valid <= 1'b1;
    end else if (bus.p_write_en) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_write_packer.sv
// Self-checking bench for fifo_write_packer (IN_BITS=8, RATIO=4, TIMEOUT=16).
// Table of packets, directed corner sequences, and a randomized phase checked
// against a queue-based packet model.
module tb_fifo_write_packer;
  localparam int IN_BITS = 8;
  localparam int RATIO   = 4;
  localparam int TIMEOUT = 16;
  localparam int WB      = async_fifo_pkg::word_bits(IN_BITS, RATIO);

  logic write_clk = 0;
  logic write_rst_n = 0;
  int   tests = 0;
  int   fails = 0;

  fifo_write_packer_if #(.IN_BITS(IN_BITS), .RATIO(RATIO)) bus ();

  fifo_write_packer #(.IN_BITS(IN_BITS), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
    .write_clk   (write_clk),
    .write_rst_n (write_rst_n),
    .bus         (bus)
  );

  always #5 write_clk = ~write_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [IN_BITS-1:0] cur[$];
  logic [WB-1:0]      exp_q[$];
  int                 cyc = 0;
  int                 last_acc = 0;

  function automatic logic [WB-1:0] mk_word(input logic l);
    logic [WB-1:0] w;
    longint unsigned d;
    d = 0;
    foreach (cur[i]) d = d + (longint'(cur[i]) << (IN_BITS * i));
    w = '0;
    w[RATIO*IN_BITS-1:0] = d[RATIO*IN_BITS-1:0];
    w[RATIO*IN_BITS +: 2] = 2'(cur.size() - 1);
    w[WB-1] = l;
    return w;
  endfunction

  // Model: one holding slot (exp_q) fed by completed packets/words.
  always @(negedge write_clk) begin
    logic pend;
    logic [WB-1:0] w;
    if (!write_rst_n) begin
      cur.delete();
      exp_q.delete();
    end else begin
      cyc++;
      pend = exp_q.size() > 0;
      chk("model_s_ready", 64'(bus.s_ready), 64'(!pend || !bus.p_write_full));
      chk("model_write_en", 64'(bus.p_write_en), 64'(pend && !bus.p_write_full));
      if (bus.p_write_en && pend) begin
        w = exp_q.pop_front();
        chk("model_write_data", 64'(bus.p_write_data), 64'(w));
      end
      if (bus.s_valid && bus.s_ready) begin
        cur.push_back(bus.s_data);
        last_acc = cyc;
        if (cur.size() == RATIO || bus.s_last) begin
          exp_q.push_back(mk_word(bus.s_last));
          cur.delete();
        end
      end
`ifdef FIFO_WRITE_PACKER_TIMEOUT_EN
      else if (cur.size() > 0 && cyc - last_acc >= TIMEOUT &&
               (exp_q.size() == 0 || !bus.p_write_full)) begin
        exp_q.push_back(mk_word(1'b0));
        cur.delete();
      end
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    bus.s_valid = 1; bus.s_data = d; bus.s_last = l;
    n = 0;
    do begin @(negedge write_clk); n++; end while (!bus.s_ready && n < 200);
    if (n >= 200) chk("send_timeout", 64'(n), 64'(0));
    @(posedge write_clk); #1;
    bus.s_valid = 0; bus.s_last = 0;
  endtask

  task automatic do_reset();
    @(posedge write_clk); #1;
    write_rst_n = 0;
    bus.s_valid = 0; bus.s_last = 0; bus.p_write_full = 0;
    repeat (2) @(negedge write_clk);
    chk("rst_s_ready", 64'(bus.s_ready), 64'(1));
    chk("rst_write_en", 64'(bus.p_write_en), 64'(0));
    chk("rst_write_data", 64'(bus.p_write_data), 64'(0));
    @(posedge write_clk); #1;
    write_rst_n = 1;
  endtask

  typedef struct {
    int               n;
    logic [3:0][7:0]  d;
    logic             lst;
    logic [WB-1:0]    exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bus.s_valid = 0; bus.s_data = 0; bus.s_last = 0; bus.p_write_full = 0;
    vecs[0] = '{n:4, d:{8'h44, 8'h33, 8'h22, 8'h11}, lst:1'b1, exp:35'h744332211};
    vecs[1] = '{n:1, d:{8'h00, 8'h00, 8'h00, 8'hA5}, lst:1'b1, exp:35'h4000000A5};
    vecs[2] = '{n:4, d:{8'hEF, 8'hBE, 8'hAD, 8'hDE}, lst:1'b0, exp:35'h3EFBEADDE};
    vecs[3] = '{n:2, d:{8'h00, 8'h00, 8'h02, 8'h01}, lst:1'b1, exp:35'h500000201};
    vecs[4] = '{n:3, d:{8'h00, 8'h80, 8'h00, 8'hFF}, lst:1'b1, exp:35'h6008000FF};

    // Reset state
    @(negedge write_clk);
    chk("reset_s_ready", 64'(bus.s_ready), 64'(1));
    chk("reset_write_en", 64'(bus.p_write_en), 64'(0));
    chk("reset_write_data", 64'(bus.p_write_data), 64'(0));
    @(posedge write_clk); #1;
    write_rst_n = 1;

    // Table: each packet's word must appear the cycle after its final accept
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < vecs[v].n; b++)
        send(vecs[v].d[b], vecs[v].lst && (b == vecs[v].n - 1));
      @(negedge write_clk);
      chk($sformatf("vec%0d_write_en", v), 64'(bus.p_write_en), 64'(1));
      chk($sformatf("vec%0d_data", v), 64'(bus.p_write_data), 64'(vecs[v].exp));
      @(posedge write_clk); #1;
    end

    // 8 back-to-back beats: no stall, writes after accepts 4 and 8
    bus.s_valid = 1; bus.s_last = 0;
    for (int i = 0; i < 8; i++) begin
      bus.s_data = 8'(8'h60 + i);
      @(negedge write_clk);
      chk("burst_ready", 64'(bus.s_ready), 64'(1));
      chk("burst_write_en", 64'(bus.p_write_en), 64'(i == 4));
      @(posedge write_clk); #1;
    end
    bus.s_valid = 0;
    @(negedge write_clk);
    chk("burst_write2_en", 64'(bus.p_write_en), 64'(1));
    chk("burst_write2_data", 64'(bus.p_write_data), 64'(35'h367666564));
    @(posedge write_clk); #1;

    // FIFO full holds the pending word
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b0);
    bus.p_write_full = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge write_clk);
      chk("full_write_en", 64'(bus.p_write_en), 64'(0));
      chk("full_s_ready", 64'(bus.s_ready), 64'(0));
      chk("full_data", 64'(bus.p_write_data), 64'(35'h313121110));
    end
    @(posedge write_clk); #1;
    bus.p_write_full = 0;
    @(negedge write_clk);
    chk("release_write_en", 64'(bus.p_write_en), 64'(1));
    @(posedge write_clk); #1;
    chk("release_s_ready", 64'(bus.s_ready), 64'(1));
    chk("release_write_en_off", 64'(bus.p_write_en), 64'(0));

    // Reset mid-packet drops the partial word
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge write_clk);
      chk("post_reset_no_write", 64'(bus.p_write_en), 64'(0));
    end
    @(posedge write_clk); #1;
    send(8'h77, 1'b1);
    @(negedge write_clk);
    chk("post_reset_write_en", 64'(bus.p_write_en), 64'(1));
    chk("post_reset_data", 64'(bus.p_write_data), 64'(35'h400000077));
    @(posedge write_clk); #1;

    // Partial word left idle
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
`ifdef FIFO_WRITE_PACKER_TIMEOUT_EN
    begin
      int seen;
      seen = 0;
      for (int j = 1; j <= 40 && seen == 0; j++) begin
        @(negedge write_clk);
        if (bus.p_write_en) begin
          seen = j;
          chk("timeout_data", 64'(bus.p_write_data), 64'(35'h200030201));
        end
      end
      chk("timeout_cycle", 64'(seen), 64'(TIMEOUT + 1));
      @(posedge write_clk); #1;
    end
`else
    for (int j = 0; j < 40; j++) begin
      @(negedge write_clk);
      chk("idle_no_write", 64'(bus.p_write_en), 64'(0));
    end
    @(posedge write_clk); #1;
    send(8'h04, 1'b1);
    @(negedge write_clk);
    chk("idle_finish_data", 64'(bus.p_write_data), 64'(35'h704030201));
    @(posedge write_clk); #1;
`endif

    // Randomized phase against the model
    for (int c = 0; c < 3000; c++) begin
      logic was;
      @(negedge write_clk);
      was = bus.s_valid && bus.s_ready;
      @(posedge write_clk); #1;
      if (!bus.s_valid || was) begin
        bus.s_valid = (c % 512 < 256) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 99) < 5);
        bus.s_data  = 8'($urandom);
        bus.s_last  = ($urandom_range(0, 9) < 2);
      end
      bus.p_write_full = ($urandom_range(0, 9) < 3);
    end
    bus.p_write_full = 0;
    @(posedge write_clk); #1;
    bus.s_valid = 0; bus.s_last = 0;
    send(8'h00, 1'b1);
    repeat (3) @(negedge write_clk);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
